// File: rtl/dnpcie_aurora_rx_path_adapter_pkg.sv
// Shared types and constants for the Aurora receive path adapter.
// Covers the buffer entry layout, the tkeep codes and the read-side states.
package dnpcie_aurora_pkg;

    localparam int DEFAULT_ADDR_BITS = 9;

    localparam logic [0:3] TKEEP_FULL = 4'hF;
    localparam logic [0:3] TKEEP_HALF = 4'hC;

    typedef enum logic [1:0] {
        IDLE,
        HI,
        LO
    } rd_state_e;

    // One store-and-forward slot: a 32-bit word plus its frame-end markers.
    typedef struct packed {
        logic [0:31] data;
        logic        last;
        logic        half;
    } rx_entry_t;

endpackage

// File: rtl/dnpcie_aurora_rx_path_adapter_if.sv
// Bus bundles: the 32-bit CRC-checked Aurora receive stream and the 16-bit AXI4-Stream output.
interface dnpcie_aurora_rx_if;
    logic [0:31] tdata;
    logic [0:3]  tkeep;
    logic        tvalid;
    logic        tlast;
    logic        crc_valid;
    logic        crc_pass_fail_n;
    logic        length_err;

    modport master (
        output tdata, tkeep, tvalid, tlast, crc_valid, crc_pass_fail_n, length_err
    );
    modport slave (
        input tdata, tkeep, tvalid, tlast, crc_valid, crc_pass_fail_n, length_err
    );
endinterface

interface dnpcie_axis16_if;
    logic [0:15] tdata;
    logic [0:1]  tkeep;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic        tuser;

    modport master (
        output tdata, tkeep, tvalid, tlast, tuser,
        input  tready
    );
    modport slave (
        input  tdata, tkeep, tvalid, tlast, tuser,
        output tready
    );
endinterface

// File: rtl/dnpcie_aurora_rx_path_adapter_ram.sv
// Simple dual-port frame buffer with a registered read port.
// The read register only updates on rd_en, so it doubles as the output holding register.
module aurora_rx_frame_ram
    import dnpcie_aurora_pkg::*;
#(
    parameter int ADDR_BITS = DEFAULT_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  rx_entry_t            wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output rx_entry_t            rd_data
);

    rx_entry_t mem [2**ADDR_BITS];
    rx_entry_t rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/dnpcie_aurora_rx_path_adapter.sv
// Store-and-forward receive adapter: 32-bit Aurora frames in, committed frames out as
// 16-bit AXI4-Stream. Bad frames are rolled back (or flagged via tuser when kept).
module dnpcie_aurora_rx_path_adapter
    import dnpcie_aurora_pkg::*;
#(
    parameter int ADDR_BITS = DEFAULT_ADDR_BITS,
    parameter bit DROP_BAD  = 1'b1
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     channel_up,
    dnpcie_aurora_rx_if.slave        s_axis,
    dnpcie_axis16_if.master          m_axis,
    output logic [15:0]              frames_ok,
    output logic [15:0]              frames_dropped,
    output logic                     overflow
);

    typedef logic [ADDR_BITS-1:0] ptr_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Assert asynchronously, release two clocks after aresetn rises.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_n;
    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rst_n      = rst_sync_q[1];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) rst_sync_q <= '0;
        else          rst_sync_q <= rst_sync_d;
    end

    ptr_t        wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d;
    logic        frame_bad_q, frame_bad_d, frame_ovf_q, frame_ovf_d, frame_any_q, frame_any_d;
    logic        overflow_q, overflow_d;
    logic [15:0] frames_ok_q, frames_ok_d, frames_dropped_q, frames_dropped_d;
    rd_state_e   state_q, state_d;

    logic        full, bad_now, ovf_now, verdict_bad;
    logic        commit_stb, commit_verdict;
    logic        ram_wr_en, ram_rd_en;
    rx_entry_t   ram_wr_data, ram_rd_data;
    ptr_t        ram_rd_addr, rd_next_ptr;
    logic        advance, rd_frame_end, out_valid;

    // Write side: speculative writes at wr_ptr, verdict on tlast commits or rolls back.
    always_comb begin
        wr_ptr_d         = wr_ptr_q;
        commit_ptr_d     = commit_ptr_q;
        frame_bad_d      = frame_bad_q;
        frame_ovf_d      = frame_ovf_q;
        frame_any_d      = frame_any_q;
        overflow_d       = overflow_q;
        frames_ok_d      = frames_ok_q;
        frames_dropped_d = frames_dropped_q;
        commit_stb       = 1'b0;
        commit_verdict   = 1'b0;
        bad_now          = frame_bad_q;
        ovf_now          = frame_ovf_q;
        verdict_bad      = 1'b0;

        full             = (wr_ptr_q + ptr_t'(1)) == rd_ptr_q;
        ram_wr_en        = channel_up && s_axis.tvalid && !full;
        ram_wr_data.data = s_axis.tdata;
        ram_wr_data.last = s_axis.tlast;
        ram_wr_data.half = s_axis.tlast && (s_axis.tkeep == TKEEP_HALF);

        if (!channel_up) begin
            if (frame_any_q) begin
                wr_ptr_d         = commit_ptr_q;
                frames_dropped_d = sat_inc(frames_dropped_q);
            end
            frame_bad_d = 1'b0;
            frame_ovf_d = 1'b0;
            frame_any_d = 1'b0;
        end else if (s_axis.tvalid) begin
            if (full) begin
                bad_now    = 1'b1;
                ovf_now    = 1'b1;
                overflow_d = 1'b1;
            end else begin
                wr_ptr_d    = wr_ptr_q + ptr_t'(1);
                frame_any_d = 1'b1;
            end
            if (!s_axis.tlast && s_axis.tkeep != TKEEP_FULL) bad_now = 1'b1;
            if (s_axis.tlast && s_axis.tkeep != TKEEP_FULL && s_axis.tkeep != TKEEP_HALF) bad_now = 1'b1;

            if (s_axis.tlast) begin
                verdict_bad = bad_now || !s_axis.crc_pass_fail_n || s_axis.length_err || !s_axis.crc_valid;
                if (!verdict_bad || (!DROP_BAD && !ovf_now)) begin
                    commit_ptr_d   = wr_ptr_d;
                    commit_stb     = 1'b1;
                    commit_verdict = verdict_bad;
                    if (!verdict_bad) frames_ok_d = frames_ok_q + 16'd1;
                end else begin
                    wr_ptr_d         = commit_ptr_q;
                    frames_dropped_d = sat_inc(frames_dropped_q);
                end
                frame_bad_d = 1'b0;
                frame_ovf_d = 1'b0;
                frame_any_d = 1'b0;
            end else begin
                frame_bad_d = bad_now;
                frame_ovf_d = ovf_now;
            end
        end
    end

    // Read side: the RAM read register holds the current entry; reading the next
    // entry on the final handshake keeps committed words streaming without bubbles.
    always_comb begin
        state_d      = state_q;
        rd_ptr_d     = rd_ptr_q;
        ram_rd_en    = 1'b0;
        ram_rd_addr  = rd_ptr_q;
        rd_next_ptr  = rd_ptr_q + ptr_t'(1);
        advance      = 1'b0;
        rd_frame_end = 1'b0;

        case (state_q)
            IDLE: begin
                if (rd_ptr_q != commit_ptr_q) begin
                    ram_rd_en = 1'b1;
                    state_d   = HI;
                end
            end
            HI: begin
                if (m_axis.tready) begin
                    if (ram_rd_data.last && ram_rd_data.half) advance = 1'b1;
                    else                                      state_d = LO;
                end
            end
            LO: begin
                if (m_axis.tready) advance = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (advance) begin
            rd_ptr_d     = rd_next_ptr;
            rd_frame_end = ram_rd_data.last;
            if (rd_next_ptr != commit_ptr_q) begin
                ram_rd_en   = 1'b1;
                ram_rd_addr = rd_next_ptr;
                state_d     = HI;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q         <= '0;
            commit_ptr_q     <= '0;
            rd_ptr_q         <= '0;
            frame_bad_q      <= 1'b0;
            frame_ovf_q      <= 1'b0;
            frame_any_q      <= 1'b0;
            overflow_q       <= 1'b0;
            frames_ok_q      <= '0;
            frames_dropped_q <= '0;
            state_q          <= IDLE;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            commit_ptr_q     <= commit_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            frame_bad_q      <= frame_bad_d;
            frame_ovf_q      <= frame_ovf_d;
            frame_any_q      <= frame_any_d;
            overflow_q       <= overflow_d;
            frames_ok_q      <= frames_ok_d;
            frames_dropped_q <= frames_dropped_d;
            state_q          <= state_d;
        end
    end

    aurora_rx_frame_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
        .clk     (aclk),
        .wr_en   (ram_wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (ram_wr_data),
        .rd_en   (ram_rd_en),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_rd_data)
    );

    assign out_valid     = (state_q != IDLE);
    assign m_axis.tvalid = out_valid;
    assign m_axis.tkeep  = out_valid ? 2'b11 : 2'b00;
    assign m_axis.tdata  = !out_valid      ? '0 :
                           (state_q == HI) ? ram_rd_data.data[0:15] : ram_rd_data.data[16:31];
    assign m_axis.tlast  = out_valid && ram_rd_data.last && ((state_q == LO) || ram_rd_data.half);

    // The verdict is only known at tlast, after earlier beats are already stored,
    // so kept bad frames carry their marker in a per-frame queue read at frame start.
    if (!DROP_BAD) begin : g_verdict
        logic verdict_mem [2**ADDR_BITS];
        ptr_t vwr_q, vwr_d, vrd_q, vrd_d;

        always_comb begin
            vwr_d = commit_stb   ? vwr_q + ptr_t'(1) : vwr_q;
            vrd_d = rd_frame_end ? vrd_q + ptr_t'(1) : vrd_q;
        end

        always_ff @(posedge aclk or negedge rst_n) begin
            if (!rst_n) begin
                vwr_q <= '0;
                vrd_q <= '0;
            end else begin
                vwr_q <= vwr_d;
                vrd_q <= vrd_d;
            end
        end

        always_ff @(posedge aclk) begin
            if (commit_stb) verdict_mem[vwr_q] <= commit_verdict;
        end

        assign m_axis.tuser = out_valid && verdict_mem[vrd_q];
    end else begin : g_no_verdict
        logic unused_verdict;
        assign unused_verdict = ^{commit_stb, commit_verdict, rd_frame_end};
        assign m_axis.tuser   = 1'b0;
    end

    assign frames_ok      = frames_ok_q;
    assign frames_dropped = frames_dropped_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_dnpcie_aurora_rx_path_adapter.sv
// Scoreboard bench for the Aurora receive path adapter (DROP_BAD=1, 512-word buffer).
module tb_dnpcie_aurora_rx_path_adapter;
    import dnpcie_aurora_pkg::*;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        channel_up;
    logic [15:0] frames_ok, frames_dropped;
    logic        overflow;

    dnpcie_aurora_rx_if s_if ();
    dnpcie_axis16_if    m_if ();

    dnpcie_aurora_rx_path_adapter #(.ADDR_BITS(9), .DROP_BAD(1'b1)) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .channel_up     (channel_up),
        .s_axis         (s_if),
        .m_axis         (m_if),
        .frames_ok      (frames_ok),
        .frames_dropped (frames_dropped),
        .overflow       (overflow)
    );

    always #5 aclk = ~aclk;

    int          checks = 0;
    int          errors = 0;
    int          ready_mode = 1;
    int          exp_ok = 0;
    int          exp_dropped = 0;
    logic [31:0] exp_q[$];
    logic [31:0] frame_words[$];
    logic        stall_prev = 1'b0;
    logic [31:0] prev_beat = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    always @(posedge aclk) begin
        #1;
        case (ready_mode)
            0:       m_if.tready = 1'b0;
            1:       m_if.tready = 1'b1;
            default: m_if.tready = 1'($urandom_range(0, 1));
        endcase
    end

    // Output monitor: pops the scoreboard on every handshake and checks stall stability.
    always @(negedge aclk) begin
        logic [31:0] got, exp;
        if (!aresetn) begin
            stall_prev = 1'b0;
        end else begin
            got = {15'b0, m_if.tlast, m_if.tdata};
            if (stall_prev) check_eq("stall_stable", got, prev_beat);
            if (m_if.tvalid && m_if.tready) begin
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
                check_eq("out_beat", got, exp);
                check_eq("out_tkeep", 32'(m_if.tkeep), 32'h3);
                check_eq("out_tuser", 32'(m_if.tuser), 32'h0);
            end
            stall_prev = m_if.tvalid && !m_if.tready;
            prev_beat  = got;
        end
    end

    task automatic idle_in();
        s_if.tvalid          = 1'b0;
        s_if.tlast           = 1'b0;
        s_if.tkeep           = 4'hF;
        s_if.crc_valid       = 1'b0;
        s_if.crc_pass_fail_n = 1'b1;
        s_if.length_err      = 1'b0;
    endtask

    task automatic drive_beat(input logic [31:0] w, input logic [3:0] keep, input logic last,
                              input logic cvld, input logic pass, input logic lerr);
        s_if.tvalid          = 1'b1;
        s_if.tdata           = w;
        s_if.tkeep           = keep;
        s_if.tlast           = last;
        s_if.crc_valid       = cvld;
        s_if.crc_pass_fail_n = pass;
        s_if.length_err      = lerr;
        tick(1);
    endtask

    // fault: 0 good, 1 crc fail, 2 length error, 3 no crc strobe, 4 bad middle tkeep, 5 bad last tkeep
    task automatic send_frame(input logic half, input int fault, input bit gaps, input bit expect_ok);
        int n = frame_words.size();
        int f = (fault == 4 && n < 2) ? 5 : fault;
        for (int i = 0; i < n; i++) begin
            logic       last = (i == n - 1);
            logic [3:0] keep = (last && half) ? 4'hC : 4'hF;
            if (gaps && $urandom_range(0, 3) == 0) begin
                idle_in();
                tick($urandom_range(1, 2));
            end
            if (f == 4 && i == 0) keep = 4'h7;
            if (f == 5 && last)   keep = 4'h8;
            drive_beat(frame_words[i], keep, last, last && f != 3, f != 1, last && f == 2);
        end
        idle_in();
        if (expect_ok) begin
            for (int i = 0; i < n; i++) begin
                logic [31:0] w = frame_words[i];
                logic        last = (i == n - 1);
                if (last && half) begin
                    exp_q.push_back({15'b0, 1'b1, w[31:16]});
                end else begin
                    exp_q.push_back({15'b0, 1'b0, w[31:16]});
                    exp_q.push_back({15'b0, last, w[15:0]});
                end
            end
            exp_ok++;
        end else begin
            exp_dropped++;
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || m_if.tvalid) && n < budget) begin
            tick(1);
            n++;
        end
        check_eq("drain_left", exp_q.size(), 0);
    endtask

    task automatic spec_frame();
        frame_words.delete();
        frame_words.push_back(32'h0001_0002);
        frame_words.push_back(32'h0003_0004);
        frame_words.push_back(32'h0005_BEEF);
    endtask

    task automatic rand_frame(input int len);
        frame_words.delete();
        for (int i = 0; i < len; i++) frame_words.push_back($urandom());
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn    = 1'b0;
        channel_up = 1'b1;
        s_if.tdata = '0;
        idle_in();
        m_if.tready = 1'b1;
        tick(3);
        check_eq("rst_tvalid", 32'(m_if.tvalid), 32'h0);
        check_eq("rst_tdata", 32'(m_if.tdata), 32'h0);
        check_eq("rst_ok", 32'(frames_ok), 32'h0);
        check_eq("rst_dropped", 32'(frames_dropped), 32'h0);
        check_eq("rst_overflow", 32'(overflow), 32'h0);
        aresetn = 1'b1;
        tick(5);

        // Spec frame, tready high: first halfword two cycles after the tlast beat.
        spec_frame();
        send_frame(1'b1, 0, 1'b0, 1'b1);
        check_eq("lat_not_yet", 32'(m_if.tvalid), 32'h0);
        tick(1);
        check_eq("lat_tvalid", 32'(m_if.tvalid), 32'h1);
        check_eq("lat_tdata", 32'(m_if.tdata), 32'h0001);
        wait_drain(100);
        check_eq("t1_frames_ok", 32'(frames_ok), 32'd1);

        // Same frame with CRC failure is dropped, the next good one is intact.
        spec_frame();
        send_frame(1'b1, 1, 1'b0, 1'b0);
        tick(4);
        check_eq("t2_no_output", 32'(m_if.tvalid), 32'h0);
        check_eq("t2_dropped", 32'(frames_dropped), 32'd1);
        rand_frame(4);
        send_frame(1'b0, 0, 1'b0, 1'b1);
        wait_drain(100);
        check_eq("t2_frames_ok", 32'(frames_ok), 32'd2);

        // Overflow: 600-beat frame behind two held frames.
        ready_mode = 0;
        tick(1);
        spec_frame();
        send_frame(1'b1, 0, 1'b0, 1'b1);
        rand_frame(2);
        send_frame(1'b0, 0, 1'b0, 1'b1);
        rand_frame(600);
        send_frame(1'b0, 0, 1'b0, 1'b0);
        tick(2);
        check_eq("ovf_flag", 32'(overflow), 32'h1);
        check_eq("ovf_ok", 32'(frames_ok), 32'(exp_ok));
        check_eq("ovf_dropped", 32'(frames_dropped), 32'(exp_dropped));
        ready_mode = 1;
        wait_drain(200);

        // channel_up drop mid-frame; a tlast beat while down must be ignored.
        ready_mode = 0;
        tick(1);
        rand_frame(3);
        send_frame(1'b0, 0, 1'b0, 1'b1);
        drive_beat($urandom(), 4'hF, 1'b0, 1'b0, 1'b1, 1'b0);
        drive_beat($urandom(), 4'hF, 1'b0, 1'b0, 1'b1, 1'b0);
        channel_up = 1'b0;
        drive_beat($urandom(), 4'hF, 1'b1, 1'b1, 1'b1, 1'b0);
        idle_in();
        tick(2);
        channel_up = 1'b1;
        exp_dropped++;
        tick(2);
        check_eq("chdn_dropped", 32'(frames_dropped), 32'(exp_dropped));
        check_eq("chdn_ok", 32'(frames_ok), 32'(exp_ok));
        ready_mode = 1;
        wait_drain(200);

        // Random traffic with 50% tready.
        ready_mode = 2;
        for (int k = 0; k < 1000; k++) begin
            int len   = $urandom_range(1, 6);
            int fault = ($urandom_range(0, 9) < 8) ? 0 : $urandom_range(1, 5);
            rand_frame(len);
            send_frame(1'($urandom_range(0, 1)), fault, 1'b1, fault == 0);
            tick(5 * len);
        end
        wait_drain(5000);
        check_eq("rand_ok", 32'(frames_ok), 32'(exp_ok));
        check_eq("rand_dropped", 32'(frames_dropped), 32'(exp_dropped));
        check_eq("rand_ovf_sticky", 32'(overflow), 32'h1);

        // Reset while a frame is held on the output.
        ready_mode = 0;
        tick(1);
        rand_frame(4);
        send_frame(1'b0, 0, 1'b0, 1'b1);
        tick(4);
        check_eq("pre_rst_tvalid", 32'(m_if.tvalid), 32'h1);
        #3;
        aresetn = 1'b0;
        #1;
        check_eq("mid_rst_tvalid", 32'(m_if.tvalid), 32'h0);
        check_eq("mid_rst_tdata", 32'(m_if.tdata), 32'h0);
        check_eq("mid_rst_tlast", 32'(m_if.tlast), 32'h0);
        check_eq("mid_rst_ok", 32'(frames_ok), 32'h0);
        check_eq("mid_rst_dropped", 32'(frames_dropped), 32'h0);
        check_eq("mid_rst_overflow", 32'(overflow), 32'h0);
        exp_q.delete();
        exp_ok      = 0;
        exp_dropped = 0;
        tick(3);
        aresetn    = 1'b1;
        ready_mode = 1;
        tick(6);
        check_eq("post_rst_empty", 32'(m_if.tvalid), 32'h0);
        spec_frame();
        send_frame(1'b1, 0, 1'b0, 1'b1);
        wait_drain(100);
        check_eq("post_rst_ok", 32'(frames_ok), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
